// File: rtl/framing_pkg.sv
// Shared constants and state type for the serial framing link.
// A frame is {SYNC, 12-bit word, even parity over the word}, sent MSB first.
package framing_pkg;
    localparam int WORD_W  = 12;
    localparam int FRAME_W = 16;
    localparam int CHAN_W  = 3;

    localparam logic [2:0] FRAME_SYNC = 3'b101;

    typedef enum logic {
        LOAD  = 1'b0,
        SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/frame_tx_sched_framer.sv
// Combinational framer: wraps a 12-bit payload into a 16-bit link frame.
// The sync pattern leads, the payload follows MSB first, and the even parity bit closes the frame.
module frame_tx_sched_framer
    import framing_pkg::*;
(
    input  logic [WORD_W-1:0]  word_i,
    output logic [FRAME_W-1:0] frame_o
);

    assign frame_o = {FRAME_SYNC, word_i, ^word_i};

endmodule

// File: rtl/frame_tx_sched.sv
// Round-robin transmit scheduler: frames one requester word (or an idle word) at a time
// and shifts frames out back-to-back, MSB first, one bit per clock.
module frame_tx_sched
    import framing_pkg::*;
#(
    parameter int                N_REQ     = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD = 12'h000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req,
    input  logic [WORD_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        ready,
    output logic                    tx_out,
    output logic                    frame_start,
    output logic [CHAN_W-1:0]       cur_chan,
    output logic                    cur_valid
);

    state_e               state_q;
    logic [3:0]           bit_cnt_q;
    logic [FRAME_W-1:0]   frame_reg_q;
    logic [CHAN_W-1:0]    rr_ptr_q;
    logic [CHAN_W-1:0]    cur_chan_q;
    logic                 cur_valid_q;

    logic                 arb;
    logic                 found;
    logic [CHAN_W-1:0]    win;
    logic [CHAN_W-1:0]    rr_ptr_d;
    logic [WORD_W-1:0]    sel_word;
    logic [FRAME_W-1:0]   sel_frame;

    // Returns {found, index}: first pending requester at or after ptr, wrapping.
    function automatic logic [CHAN_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [CHAN_W-1:0] ptr);
        logic              hit;
        logic [CHAN_W-1:0] idx;
        int                cand;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!hit && r[cand]) begin
                hit = 1'b1;
                idx = CHAN_W'(cand);
            end
        end
        return {hit, idx};
    endfunction

    always_comb begin
        arb = !rst && en && ((state_q == LOAD) || (bit_cnt_q == 4'd0));
        {found, win} = rr_pick(req, rr_ptr_q);
        rr_ptr_d = (win == CHAN_W'(N_REQ - 1)) ? '0 : win + 3'd1;
        sel_word = IDLE_WORD;
        ready    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (found && (win == CHAN_W'(i))) begin
                sel_word = req_data[i*WORD_W +: WORD_W];
                ready[i] = arb;
            end
        end
    end

    frame_tx_sched_framer u_framer (
        .word_i  (sel_word),
        .frame_o (sel_frame)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            bit_cnt_q   <= 4'd15;
            frame_reg_q <= '0;
            rr_ptr_q    <= '0;
            cur_chan_q  <= '0;
            cur_valid_q <= 1'b0;
        end else if (arb) begin
            // Arbitration reloads the shifter so the next bit 15 follows with no gap.
            state_q     <= SHIFT;
            bit_cnt_q   <= 4'd15;
            frame_reg_q <= sel_frame;
            cur_valid_q <= found;
            if (found) begin
                cur_chan_q <= win;
                rr_ptr_q   <= rr_ptr_d;
            end
        end else if (state_q == SHIFT) begin
            if (bit_cnt_q != 4'd0) begin
                bit_cnt_q <= bit_cnt_q - 4'd1;
            end else begin
                state_q     <= LOAD;
                bit_cnt_q   <= 4'd15;
                cur_valid_q <= 1'b0;
            end
        end
    end

    assign tx_out      = (state_q == SHIFT) ? frame_reg_q[bit_cnt_q] : 1'b0;
    assign frame_start = (state_q == SHIFT) && (bit_cnt_q == 4'd15);
    assign cur_chan    = cur_chan_q;
    assign cur_valid   = cur_valid_q;

endmodule

// File: tb/tb_frame_tx_sched.sv
// Directed bench for frame_tx_sched: a round-robin reference model pushes the expected
// {valid, chan, frame} at every arbitration and each shifted-out frame is popped and compared.
module tb_frame_tx_sched;
    localparam int          N    = 4;
    localparam logic [11:0] IDLE = 12'h000;
    localparam int          W    = 20;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [12*N-1:0] req_data;
    logic [N-1:0]  ready;
    logic          tx_out;
    logic          frame_start;
    logic [2:0]    cur_chan;
    logic          cur_valid;

    logic [W-1:0]  exp_q[$];
    int            total;
    int            bad;
    int            m_rr;
    int            m_chan;
    logic          auto_drop;

    frame_tx_sched #(.N_REQ(N), .IDLE_WORD(IDLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .ready       (ready),
        .tx_out      (tx_out),
        .frame_start (frame_start),
        .cur_chan    (cur_chan),
        .cur_valid   (cur_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_frame(input logic [11:0] w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 12; i++) p = p ^ w[i];
        return {3'b101, w, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called inside an arbitration cycle, after inputs are settled.
    task automatic arb_model(input string tag);
        int           win;
        int           idx;
        logic [N-1:0] exp_rdy;
        logic [11:0]  w;
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (win < 0 && req[idx]) win = idx;
        end
        exp_rdy = '0;
        if (win >= 0) begin
            exp_rdy[win] = 1'b1;
            w      = req_data[win*12 +: 12];
            m_chan = win;
            m_rr   = (win + 1) % N;
            exp_q.push_back({1'b1, 3'(win), model_frame(w)});
        end else begin
            exp_q.push_back({1'b0, 3'(m_chan), model_frame(IDLE)});
        end
        chk({tag, "_ready"}, 32'(ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (win >= 0 && auto_drop) req[win] = 1'b0;
    endtask

    // Shifts one frame out and compares it; the last bit cycle is the next arbitration.
    task automatic run_frame(input string tag);
        logic [W-1:0]  e;
        logic [15:0]   got;
        logic [15:0]   fs;
        logic          rdy_mid;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        e       = exp_q.pop_front();
        got     = '0;
        fs      = '0;
        rdy_mid = 1'b0;
        for (int b = 15; b >= 0; b--) begin
            @(negedge clk);
            #1;
            got[b] = tx_out;
            fs[b]  = frame_start;
            if (b == 15) begin
                chk({tag, "_chan"}, 32'(cur_chan), 32'(e[18:16]));
                chk({tag, "_valid"}, 32'(cur_valid), 32'(e[19]));
            end
            if (b > 0) begin
                rdy_mid = rdy_mid | (|ready);
            end else begin
                chk({tag, "_frame"}, 32'(got), 32'(e[15:0]));
                chk({tag, "_fstart"}, 32'(fs), 32'h8000);
                chk({tag, "_rdy_mid"}, 32'(rdy_mid), 32'h0);
                if (en) arb_model(tag);
                else chk({tag, "_rdy_off"}, 32'(ready), 32'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        m_rr      = 0;
        m_chan    = 0;
        auto_drop = 1'b1;
        rst       = 1'b1;
        en        = 1'b1;
        req       = 4'b0001;
        for (int i = 0; i < N; i++) req_data[i*12 +: 12] = 12'h100 + 12'(i);

        // Reset values, with a pending request and en high that must not be granted.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_tx", 32'(tx_out), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_chan", 32'(cur_chan), 32'h0);
        chk("rst_valid", 32'(cur_valid), 32'h0);

        // Idle frames after release.
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        arb_model("idle0");
        run_frame("idle1");

        // Single requester on channel 2.
        req_data[2*12 +: 12] = 12'h5A3;
        req[2] = 1'b1;
        run_frame("idle2");
        run_frame("ch2");
        run_frame("after_ch2");

        // Reset in the middle of a data frame (frame bit 7 is a 1 for 12'h3C7).
        req_data[1*12 +: 12] = 12'h3C7;
        req[1] = 1'b1;
        run_frame("pre_rst");
        void'(exp_q.pop_front());
        for (int b = 15; b >= 7; b--) begin
            @(negedge clk);
        end
        #1;
        chk("mid_tx", 32'(tx_out), 32'h1);
        chk("mid_valid", 32'(cur_valid), 32'h1);
        req = 4'b1001;
        rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx_out), 32'h0);
        chk("arst_ready", 32'(ready), 32'h0);
        chk("arst_fs", 32'(frame_start), 32'h0);
        chk("arst_valid", 32'(cur_valid), 32'h0);
        chk("arst_chan", 32'(cur_chan), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        m_rr   = 0;
        m_chan = 0;
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*12 +: 12] = 12'h100 + 12'(i);
        #1;
        arb_model("rel");

        // All requesters held: grants must rotate 0,1,2,3,0,1 with no gap.
        req = 4'b1111;
        for (int f = 0; f < 6; f++) begin
            if (f == 5) begin
                req = '0;
                auto_drop = 1'b1;
            end
            run_frame($sformatf("rr%0d", f));
        end

        // en dropped mid-frame: frame completes, then the line goes quiet.
        en = 1'b0;
        run_frame("en_off");
        req_data[1*12 +: 12] = 12'h0F0;
        req[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("off%0d_tx", c), 32'(tx_out), 32'h0);
            chk($sformatf("off%0d_ready", c), 32'(ready), 32'h0);
            chk($sformatf("off%0d_fs", c), 32'(frame_start), 32'h0);
            chk($sformatf("off%0d_valid", c), 32'(cur_valid), 32'h0);
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        arb_model("en_on");
        run_frame("ch1");
        run_frame("tail_idle");

        if (exp_q.size() != 1) begin
            total++;
            bad++;
            $error("FAIL sb_depth observed=%0d expected=1", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_tx_sched.md
Name: frame_tx_sched

Overview:
Transmit-side scheduler for the serial framing link. It lets N_REQ requesters share one serial line: it round-robin arbitrates among pending 12-bit words, frames the winner with the existing framer, and shifts the 16-bit frame out MSB first, one bit per clock. Frames go out back-to-back with no gap cycles, so the downstream r_framer sees a continuous frame stream. When no requester is pending, an idle frame carrying IDLE_WORD is sent so the receiver keeps frame lock.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDLE_WORD, 12'h000, payload framed and sent when no request is pending

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  link enable; sampled only at frame boundaries
req  in  N_REQ  per-requester valid
req_data  in  12*N_REQ  packed words; requester i occupies bits [12*i+11 : 12*i]
ready  out  N_REQ  one-cycle grant pulse; a transfer occurs when req[i] and ready[i] are both high
tx_out  out  1  serial frame bit
frame_start  out  1  high during the cycle that carries frame bit 15
cur_chan  out  3  index of the requester whose frame is on the line
cur_valid  out  1  1 = current frame carries requester data; 0 = idle frame

Behaviour:
- States: LOAD and SHIFT.
- Reset (async, any cycle, including mid-frame):
  - state=LOAD, bit_cnt=15, frame_reg=0, rr_ptr=0.
  - tx_out=0, frame_start=0, ready=0, cur_chan=0, cur_valid=0.
  - A frame in progress is abandoned with no partial completion.
- Arbitration cycle: a LOAD cycle with en=1, or the SHIFT cycle with bit_cnt==0 and en=1.
  - Winner is the first i with req[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - ready[winner]=1 (combinational) in that cycle only. All other ready bits stay 0.
  - At the clock edge: frame_reg <= framer(req_data[winner]), cur_chan <= winner, cur_valid <= 1, rr_ptr <= (winner+1) mod N_REQ, bit_cnt <= 15, state <= SHIFT.
  - No req bit set: frame_reg <= framer(IDLE_WORD), cur_valid <= 0, cur_chan and rr_ptr hold, no ready asserted.
- LOAD with en=0: stay in LOAD. tx_out=0, no ready asserted.
- SHIFT:
  - tx_out = frame_reg[bit_cnt]; frame_start = (bit_cnt==15).
  - bit_cnt decrements by 1 per cycle.
  - At bit_cnt==0:
    - en=1: arbitration cycle (above). The next frame's bit 15 follows immediately, giving a 16-cycle frame period and zero gap.
    - en=0: state <= LOAD, cur_valid <= 0.
- Latency: in LOAD with en=1, a word granted in cycle t has its bit 15 on tx_out in cycle t+1 and bit 0 in cycle t+16.
- Requester rules:
  - Hold req and data stable until ready.
  - req may drop before grant; no transfer occurs.
  - data is sampled only in the ready cycle.
- Fairness: with all requesters continuously pending, each receives exactly one grant per N_REQ frames.
- A req asserted during the arbitration cycle itself is eligible in that cycle (combinational sampling).
- Widths: bit_cnt 4 bits. rr_ptr and cur_chan are 3 bits; values >= N_REQ never occur.

Decomposition:
- Shared package (framing_pkg):
  - constants WORD_W=12, FRAME_W=16, CHAN_W=3
  - state enum {LOAD, SHIFT}
- One sub-module instance: the existing combinational framer (12 -> 16) on the muxed winner/idle word.
- Round-robin selection is an internal function, not a separate module.

Test Plan:
- Reset, en=1, no req -> cycles 1..16 tx_out equals framer(12'h000) bits 15..0; frame_start high every 16th cycle; cur_valid=0; ready never asserted.
- req[2]=1 with data 12'h5A3 -> ready[2] pulses exactly once; the following 16 bits equal framer(12'h5A3) MSB first; cur_chan=2, cur_valid=1; the next frame is idle.
- All four req held high, data 12'h100+i -> grant order 0,1,2,3,0,1; ready pulses spaced exactly 16 cycles apart; no gap between frames.
- Loopback: tx_out into r_framer with words 12'h001..12'h010 -> after lock, r_framer data_out matches each word in order with correct=1.
- Reset asserted at bit_cnt=7 of a data frame -> tx_out, ready, frame_start, cur_valid go to 0 immediately without a clock edge; after release, the first frame starts with rr_ptr=0.
- en dropped mid-frame -> the current frame completes all 16 bits, then tx_out=0 and no ready is asserted; re-raising en -> the next cycle is an arbitration cycle.
